// File: rtl/bus_master_port.sv
// bus_master_port: initiator end of the serial bus. Turns parallel read/write
// requests into a header/address/data bit stream for the slave, for single
// or burst transfers, with a response timeout so a dead slave cannot hang it.
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready/req_wren/req_burst/req_addr : request handshake
//   wdata/wdata_valid/wdata_ready                   : write word supply
//   rdata/rdata_valid                               : read word return
//   done/err                                        : end-of-transaction pulses
//   validIn/wren/BurstEn/Address/DataIn             : serial lines to slave
//   ready/validOut/DataOut                          : serial lines from slave
module bus_master_port #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BURST_LEN = 128,
    parameter int unsigned TIMEOUT   = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wren,
    input  logic              req_burst,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              done,
    output logic              err,
    output logic              validIn,
    output logic              wren,
    output logic              BurstEn,
    output logic              Address,
    output logic              DataIn,
    input  logic              ready,
    input  logic              validOut,
    input  logic              DataOut
);

    localparam int unsigned MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int unsigned BIT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [3:0] {
        S_IDLE, S_HDR, S_ADDR, S_WLOAD, S_WDATA, S_WWAIT, S_RWAIT, S_RDATA, S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_sr;
    logic              wren_q;
    logic [CNT_W-1:0]  word_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] wsr;
    logic [DATA_W-2:0] rsr;
    logic [TO_W-1:0]   tcnt;

    logic addr_last_c;
    logic timeout_c;
    logic load_c;

    // Last address bit is on the line this cycle.
    assign addr_last_c = (state == S_ADDR) && (bit_cnt == BIT_W'(ADDR_W - 1));
    assign timeout_c   = (tcnt == TO_W'(TIMEOUT - 1));
    // A write word is taken on any edge that would otherwise enter or sit in
    // WLOAD, so a word already waiting costs no idle cycle.
    assign load_c = wdata_valid &&
                    ((addr_last_c && wren_q) ||
                     ((state == S_WWAIT) && ready) ||
                     (state == S_WLOAD));

    // Transaction sequencer with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            addr_sr     <= '0;
            wren_q      <= 1'b0;
            word_cnt    <= '0;
            bit_cnt     <= '0;
            wsr         <= '0;
            rsr         <= '0;
            tcnt        <= '0;
            req_ready   <= 1'b1;
            wdata_ready <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            validIn     <= 1'b0;
            wren        <= 1'b0;
            BurstEn     <= 1'b0;
            Address     <= 1'b0;
            DataIn      <= 1'b0;
        end else begin
            wdata_ready <= 1'b0;
            rdata_valid <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_sr   <= req_addr;
                        wren_q    <= req_wren;
                        word_cnt  <= req_burst ? CNT_W'(BURST_LEN) : CNT_W'(1);
                        req_ready <= 1'b0;
                        validIn   <= 1'b1;
                        wren      <= req_wren;
                        BurstEn   <= req_burst;
                        state     <= S_HDR;
                    end
                end
                S_HDR: begin
                    Address <= addr_sr[ADDR_W-1];
                    addr_sr <= addr_sr << 1;
                    bit_cnt <= '0;
                    state   <= S_ADDR;
                end
                S_ADDR: begin
                    if (addr_last_c) begin
                        validIn <= 1'b0;
                        wren    <= 1'b0;
                        BurstEn <= 1'b0;
                        Address <= 1'b0;
                        bit_cnt <= '0;
                        tcnt    <= '0;
                        state   <= wren_q ? S_WLOAD : S_RWAIT;
                    end else begin
                        Address <= addr_sr[ADDR_W-1];
                        addr_sr <= addr_sr << 1;
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end
                S_WLOAD: begin
                    // Leaves only through the load path below.
                end
                S_WDATA: begin
                    if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                        validIn  <= 1'b0;
                        DataIn   <= 1'b0;
                        word_cnt <= word_cnt - CNT_W'(1);
                        tcnt     <= '0;
                        if (word_cnt == CNT_W'(1)) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= S_WWAIT;
                        end
                    end else begin
                        DataIn  <= wsr[DATA_W-1];
                        wsr     <= wsr << 1;
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end
                S_WWAIT: begin
                    if (ready) begin
                        state <= S_WLOAD;
                    end else if (timeout_c) begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        tcnt  <= '0;
                        state <= S_DONE;
                    end else begin
                        tcnt <= tcnt + TO_W'(1);
                    end
                end
                S_RWAIT: begin
                    if (validOut) begin
                        rsr     <= (DATA_W-1)'(DataOut);
                        bit_cnt <= BIT_W'(1);
                        tcnt    <= '0;
                        state   <= S_RDATA;
                    end else if (timeout_c) begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        tcnt  <= '0;
                        state <= S_DONE;
                    end else begin
                        tcnt <= tcnt + TO_W'(1);
                    end
                end
                S_RDATA: begin
                    // bit_cnt holds the number of bits already captured.
                    if (validOut) begin
                        tcnt <= '0;
                        if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                            rdata       <= {rsr, DataOut};
                            rdata_valid <= 1'b1;
                            word_cnt    <= word_cnt - CNT_W'(1);
                            bit_cnt     <= '0;
                            if (word_cnt == CNT_W'(1)) begin
                                done  <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                state <= S_RWAIT;
                            end
                        end else begin
                            rsr     <= (DATA_W-1)'({rsr, DataOut});
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end else if (timeout_c) begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        tcnt  <= '0;
                        state <= S_DONE;
                    end else begin
                        tcnt <= tcnt + TO_W'(1);
                    end
                end
                S_DONE: begin
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // Write word load: first data bit goes out on the next cycle.
            if (load_c) begin
                wdata_ready <= 1'b1;
                wsr         <= wdata << 1;
                DataIn      <= wdata[DATA_W-1];
                validIn     <= 1'b1;
                bit_cnt     <= '0;
                tcnt        <= '0;
                state       <= S_WDATA;
            end
        end
    end

endmodule

// File: tb/tb_bus_master_port.sv
// tb_bus_master_port: scoreboard bench for bus_master_port. Expected serial
// bits and read words are queued when stimulus is built and popped as the
// DUT produces them.
module tb_bus_master_port;

    localparam int unsigned ADDR_W    = 12;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned BURST_LEN = 128;
    localparam int unsigned TIMEOUT   = 1023;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid, req_ready, req_wren, req_burst;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] wdata, rdata;
    logic              wdata_valid, wdata_ready, rdata_valid, done, err;
    logic              validIn, wren, BurstEn, Address, DataIn;
    logic              ready, validOut, DataOut;

    int n_cmp = 0;
    int n_bad = 0;

    logic              exp_bits[$];
    logic [DATA_W-1:0] exp_words[$];
    logic [DATA_W-1:0] wq[$];

    always #5 clk = ~clk;

    bus_master_port #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wren(req_wren),
        .req_burst(req_burst), .req_addr(req_addr),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .rdata(rdata), .rdata_valid(rdata_valid), .done(done), .err(err),
        .validIn(validIn), .wren(wren), .BurstEn(BurstEn), .Address(Address),
        .DataIn(DataIn), .ready(ready), .validOut(validOut), .DataOut(DataOut)
    );

    task automatic test_reset;
        reset = 1'b0;
        req_valid = 0; req_wren = 0; req_burst = 0; req_addr = '0;
        wdata = '0; wdata_valid = 0; ready = 0; validOut = 0; DataOut = 0;
        repeat (2) @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        n_cmp++; if ({validIn, wren, BurstEn, Address, DataIn} !== 5'b0) begin n_bad++; $display("FAIL reset_serial got %b want 00000", {validIn, wren, BurstEn, Address, DataIn}); end
        n_cmp++; if ({wdata_ready, rdata_valid, done, err} !== 4'b0) begin n_bad++; $display("FAIL reset_pulses got %b want 0000", {wdata_ready, rdata_valid, done, err}); end
        n_cmp++; if (rdata !== '0) begin n_bad++; $display("FAIL reset_rdata got %h want 00", rdata); end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1 || validIn !== 1'b0) begin n_bad++; $display("FAIL post_reset_idle got rr=%b vi=%b want rr=1 vi=0", req_ready, validIn); end
    endtask

    // Drives one write transaction and checks header, address and data bits.
    task automatic do_write(input logic [ADDR_W-1:0] addr, input logic burst,
                            input logic [DATA_W-1:0] w0, input string tag);
        int nw, vcnt, dbits, pulses, rdy_t, cyc;
        bit fin;
        logic e;
        logic [DATA_W-1:0] w;
        nw = burst ? int'(BURST_LEN) : 1;
        vcnt = 0; dbits = 0; pulses = 0; rdy_t = 0; cyc = 0; fin = 0;
        exp_bits.delete(); wq.delete();
        for (int i = ADDR_W - 1; i >= 0; i--) exp_bits.push_back(addr[i]);
        for (int k = 0; k < nw; k++) begin
            w = (k == 0) ? w0 : DATA_W'($urandom);
            wq.push_back(w);
            for (int i = DATA_W - 1; i >= 0; i--) exp_bits.push_back(w[i]);
        end
        @(negedge clk);
        req_valid = 1; req_wren = 1; req_burst = burst; req_addr = addr;
        wdata_valid = 1; wdata = wq[0];
        while (!fin && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            req_valid = 0;
            ready = 0;
            if (rdy_t > 0) begin
                rdy_t--;
                if (rdy_t == 0) ready = 1;
            end
            if (validIn) begin
                if (vcnt == 0) begin
                    n_cmp++; if (wren !== 1'b1 || BurstEn !== burst) begin n_bad++; $display("FAIL %s hdr got wren=%b burst=%b want 1 %b", tag, wren, BurstEn, burst); end
                end else if (exp_bits.size() == 0) begin
                    n_cmp++; n_bad++; $display("FAIL %s extra_bit got validIn=1 want 0", tag);
                end else begin
                    e = exp_bits.pop_front();
                    if (vcnt <= int'(ADDR_W)) begin
                        n_cmp++; if (Address !== e || wren !== 1'b1 || BurstEn !== burst) begin n_bad++; $display("FAIL %s addr_bit%0d got a=%b w=%b b=%b want %b 1 %b", tag, vcnt - 1, Address, wren, BurstEn, e, burst); end
                    end else begin
                        n_cmp++; if (DataIn !== e || Address !== 1'b0) begin n_bad++; $display("FAIL %s data_bit%0d got d=%b a=%b want %b 0", tag, dbits, DataIn, Address, e); end
                        dbits++;
                        if (dbits % int'(DATA_W) == 0) rdy_t = 5;
                    end
                end
                vcnt++;
            end
            if (wdata_ready) begin
                pulses++;
                if (wq.size() > 0) void'(wq.pop_front());
                wdata_valid = (wq.size() > 0);
                wdata = (wq.size() > 0) ? wq[0] : '0;
            end
            if (done) begin
                n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL %s done_err got %b want 0", tag, err); end
                fin = 1;
            end
        end
        ready = 0; wdata_valid = 0;
        n_cmp++; if (!fin) begin n_bad++; $display("FAIL %s done_timeout got no done want done within budget", tag); end
        n_cmp++; if (pulses !== nw) begin n_bad++; $display("FAIL %s wdata_ready_count got %0d want %0d", tag, pulses, nw); end
        n_cmp++; if (exp_bits.size() !== 0) begin n_bad++; $display("FAIL %s bits_left got %0d want 0", tag, exp_bits.size()); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL %s after_done got done=%b rr=%b want 0 1", tag, done, req_ready); end
    endtask

    // Drives one read transaction with a bit schedule for the slave.
    task automatic do_read(input logic [ADDR_W-1:0] addr, input logic burst, input bit gap,
                           input logic [DATA_W-1:0] w0, input string tag);
        int nw, vcnt, rv, cyc;
        bit fin, in_rd;
        logic e;
        logic [DATA_W-1:0] w;
        logic sv[$];
        logic so[$];
        nw = burst ? int'(BURST_LEN) : 1;
        vcnt = 0; rv = 0; cyc = 0; fin = 0; in_rd = 0;
        exp_bits.delete(); exp_words.delete();
        for (int i = ADDR_W - 1; i >= 0; i--) exp_bits.push_back(addr[i]);
        for (int i = 0; i < 4; i++) begin sv.push_back(1'b0); so.push_back(1'b0); end
        for (int k = 0; k < nw; k++) begin
            w = (k == 0) ? w0 : DATA_W'($urandom);
            exp_words.push_back(w);
            for (int i = DATA_W - 1; i >= 0; i--) begin
                sv.push_back(1'b1); so.push_back(w[i]);
                if (gap && i == 4) for (int g = 0; g < 3; g++) begin sv.push_back(1'b0); so.push_back(1'b1); end
            end
            if (gap && (k % 2 == 1)) begin sv.push_back(1'b0); so.push_back(1'b0); end
        end
        @(negedge clk);
        req_valid = 1; req_wren = 0; req_burst = burst; req_addr = addr; wdata_valid = 0;
        while (!fin && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            req_valid = 0;
            n_cmp++; if (DataIn !== 1'b0) begin n_bad++; $display("FAIL %s datain_idle got %b want 0", tag, DataIn); end
            if (validIn) begin
                if (vcnt == 0) begin
                    n_cmp++; if (wren !== 1'b0 || BurstEn !== burst) begin n_bad++; $display("FAIL %s hdr got wren=%b burst=%b want 0 %b", tag, wren, BurstEn, burst); end
                end else if (exp_bits.size() > 0) begin
                    e = exp_bits.pop_front();
                    n_cmp++; if (Address !== e) begin n_bad++; $display("FAIL %s addr_bit%0d got %b want %b", tag, vcnt - 1, Address, e); end
                end
                vcnt++;
            end else if (!in_rd && vcnt == int'(ADDR_W) + 1) begin
                in_rd = 1;
            end
            if (in_rd && sv.size() > 0) begin
                validOut = sv.pop_front(); DataOut = so.pop_front();
            end else begin
                validOut = 0; DataOut = 0;
            end
            if (rdata_valid) begin
                rv++;
                if (exp_words.size() == 0) begin
                    n_cmp++; n_bad++; $display("FAIL %s extra_rdata_valid got %h want none", tag, rdata);
                end else begin
                    w = exp_words.pop_front();
                    n_cmp++; if (rdata !== w) begin n_bad++; $display("FAIL %s rdata%0d got %h want %h", tag, rv - 1, rdata, w); end
                end
            end
            if (done) begin
                n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL %s done_err got %b want 0", tag, err); end
                fin = 1;
            end
        end
        validOut = 0; DataOut = 0;
        n_cmp++; if (!fin) begin n_bad++; $display("FAIL %s done_timeout got no done want done within budget", tag); end
        n_cmp++; if (rv !== nw) begin n_bad++; $display("FAIL %s rdata_valid_count got %0d want %0d", tag, rv, nw); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || req_ready !== 1'b1 || rdata_valid !== 1'b0) begin n_bad++; $display("FAIL %s after_done got done=%b rr=%b rv=%b want 0 1 0", tag, done, req_ready, rdata_valid); end
    endtask

    task automatic test_single_write;
        do_write(12'h12B, 1'b0, 8'hA5, "single_write");
    endtask

    task automatic test_burst_write;
        do_write(12'h7E1, 1'b1, 8'h3D, "burst_write");
    endtask

    task automatic test_single_read;
        do_read(12'h0FF, 1'b0, 1'b0, 8'h3C, "single_read");
    endtask

    task automatic test_burst_read;
        do_read(12'h9A4, 1'b1, 1'b1, 8'hE7, "burst_read");
    endtask

    task automatic test_timeout;
        int vcnt, n, cyc;
        bit started, fin;
        vcnt = 0; n = 0; cyc = 0; started = 0; fin = 0;
        validOut = 0; DataOut = 0;
        @(negedge clk);
        req_valid = 1; req_wren = 0; req_burst = 0; req_addr = 12'h555;
        while (!fin && cyc < int'(TIMEOUT) + 200) begin
            @(negedge clk);
            cyc++;
            req_valid = 0;
            if (started) n++;
            if (validIn) vcnt++;
            else if (!started && vcnt == int'(ADDR_W) + 1) started = 1;
            if (done) begin
                fin = 1;
                n_cmp++; if (n !== int'(TIMEOUT) || !started) begin n_bad++; $display("FAIL timeout_latency got %0d want %0d", n, TIMEOUT); end
                n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL timeout_err got %b want 1", err); end
                n_cmp++; if ({validIn, Address, DataIn, wren, BurstEn} !== 5'b0) begin n_bad++; $display("FAIL timeout_serial got %b want 00000", {validIn, Address, DataIn, wren, BurstEn}); end
            end
        end
        n_cmp++; if (!fin) begin n_bad++; $display("FAIL timeout_done got no done want done after %0d", TIMEOUT); end
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL timeout_after got rr=%b done=%b err=%b want 1 0 0", req_ready, done, err); end
    endtask

    task automatic test_reset_mid;
        int cyc;
        for (int pass = 0; pass < 2; pass++) begin
            cyc = 0;
            @(negedge clk);
            req_valid = 1; req_wren = 1; req_burst = 0; req_addr = 12'h5A5;
            wdata_valid = 1; wdata = 8'hC3;
            @(negedge clk);
            req_valid = 0;
            while (validIn !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
            n_cmp++; if (validIn !== 1'b1) begin n_bad++; $display("FAIL rst_mid%0d start got validIn=%b want 1", pass, validIn); end
            repeat (pass == 0 ? 5 : 16) @(negedge clk);
            #2 reset = 1'b0;
            #1;
            n_cmp++; if ({validIn, wren, BurstEn, Address, DataIn} !== 5'b0) begin n_bad++; $display("FAIL rst_mid%0d serial got %b want 00000", pass, {validIn, wren, BurstEn, Address, DataIn}); end
            n_cmp++; if (req_ready !== 1'b1 || {wdata_ready, done, err} !== 3'b0) begin n_bad++; $display("FAIL rst_mid%0d ctrl got rr=%b pulses=%b want 1 000", pass, req_ready, {wdata_ready, done, err}); end
            wdata_valid = 0;
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            n_cmp++; if (done !== 1'b0 || validIn !== 1'b0) begin n_bad++; $display("FAIL rst_mid%0d no_partial got done=%b vi=%b want 0 0", pass, done, validIn); end
        end
        do_write(12'h3C7, 1'b0, 8'h69, "post_reset_write");
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_burst_write();
        test_single_read();
        test_burst_read();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_master_port.md
Name: bus_master_port

Overview:
- Initiator end of the serial bus: converts parallel read/write requests from a local controller into the bit-serial transaction format the bus slave expects.
- Sends the address serially, then either serializes write data or deserializes read data, for single or burst transfers.
- Sits between the arbiter/controller and the serial bus lines driving the slave.
- Includes a response timeout so a dead slave cannot hang the bus.

Parameters:
- ADDR_W, 12, address bits shifted per transaction.
- DATA_W, 8, bits per data word.
- BURST_LEN, 128, words per burst transfer (1..255).
- TIMEOUT, 1023, max cycles waiting for slave ready/validOut before abort.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset; one clock domain (clk).
- req_valid  input  1  request present.
- req_ready  output  1  high in IDLE; request accepted when req_valid & req_ready.
- req_wren  input  1  1=write, 0=read.
- req_burst  input  1  1=BURST_LEN words, 0=single word.
- req_addr  input  ADDR_W  start address.
- wdata  input  DATA_W  write word.
- wdata_valid  input  1  wdata present.
- wdata_ready  output  1  one-cycle pulse when wdata is loaded.
- rdata  output  DATA_W  read word.
- rdata_valid  output  1  one-cycle pulse per completed read word.
- done  output  1  one-cycle pulse at end of transaction.
- err  output  1  one-cycle pulse with done on timeout abort.
- validIn  output  1  serial valid to slave.
- wren  output  1  serial write enable to slave.
- BurstEn  output  1  serial burst flag to slave.
- Address  output  1  serial address bit.
- DataIn  output  1  serial write data bit.
- ready  input  1  slave ready for next write word.
- validOut  input  1  slave read data valid.
- DataOut  input  1  serial read data bit.

Behaviour:
- Reset, asynchronous, any state: every output 0 except req_ready=1; state IDLE; all counters 0. No partial completion is reported.
- IDLE:
  - On accept, latch addr, wren and burst.
  - Word count = BURST_LEN if burst, else 1.
  - Go to HDR.
- HDR, 1 cycle:
  - validIn=1, wren=latched wren, BurstEn=latched burst.
  - validIn, wren and BurstEn stay constant until the last address bit.
- ADDR, ADDR_W cycles:
  - Address driven MSB first, one bit per cycle, validIn=1.
  - Write: go to WLOAD. Read: go to RWAIT.
- WLOAD:
  - Wait for wdata_valid, with validIn=0.
  - Then pulse wdata_ready, load the shift register, go to WDATA.
  - The first word is loaded with no gap if wdata_valid is already high.
- WDATA, DATA_W cycles:
  - validIn=1, DataIn MSB first; Address=0.
  - Afterwards: decrement the word count, then validIn=0.
  - If count=0, go to DONE; else go to WWAIT.
- WWAIT:
  - Wait for ready=1 (level, sampled), then go to WLOAD.
  - The address is not resent; the slave increments it.
- RWAIT:
  - All serial outputs 0.
  - On validOut=1, go to RDATA; the first bit is captured in the same cycle.
- RDATA:
  - Shift DataOut in MSB first while validOut=1, exactly DATA_W bits.
  - validOut dropping early: hold the partial word, resume on the next validOut=1.
  - After the DATA_W-th bit: rdata updated and rdata_valid pulsed the next cycle; decrement the count.
  - count=0: go to DONE; else go to RWAIT.
- Timeout:
  - A counter runs in WWAIT, RWAIT and partial RDATA; it clears on any state change.
  - On reaching TIMEOUT: serial outputs 0, go to DONE with err=1.
- DONE, 1 cycle: done=1, then IDLE. req_ready returns 1 the following cycle.
- Word count is 8-bit, loaded directly; BURST_LEN=1 behaves as single.
- req_valid outside IDLE is ignored.

Test Plan:
- Single write: addr 0x12B, data 0xA5, burst=0 → validIn high 1+12 cycles with Address bits 0,0,0,1,0,0,1,0,1,0,1,1; then 8 cycles of DataIn bits 1,0,1,0,0,1,0,1; done pulses; wdata_ready pulses exactly once.
- Burst write, BURST_LEN=128, slave model raises ready 5 cycles after each word → address sent once, 128 wdata_ready pulses, 128×8 data bits, BurstEn=1 during header, single done.
- Single read, addr 0x0FF, slave returns 0x3C 4 cycles after the address → rdata=0x3C, one rdata_valid, done; DataIn stays 0.
- Burst read with validOut gapped mid-word → 128 correct words, in order, with no extra rdata_valid.
- Timeout: read with validOut never asserted → done and err pulse exactly TIMEOUT cycles after RWAIT is entered; req_ready=1 the next cycle.
- Reset asserted in mid-ADDR and again in mid-WDATA → outputs 0 immediately (asynchronous); after release, a new single write completes correctly.
